// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: word-level sequencer for a bit-serial Mealy pattern detector.
// Takes a word over in_valid/in_ready and shifts it LSB-first into the detector,
// one bit per clk. It samples det_y on each bit and returns the hit count and
// first-hit index over out_valid/out_ready.
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   in_valid/in_data/in_ready   word input handshake
//   abort                 synchronous abandon of the word being shifted
//   det_rst_n/det_xin/det_y     detector reset, serial bit, Mealy output
//   out_valid/out_ready   result handshake
//   out_count/out_any/out_first result: saturating hits, any-hit flag, first-hit index
module seq_scan_ctrl #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned IDX_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    input  logic              abort,
    output logic              det_rst_n,
    output logic              det_xin,
    input  logic              det_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_any,
    output logic [IDX_W-1:0]  out_first
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  sreg_q, sreg_d;
    logic [IDX_W-1:0]   bit_q, bit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               any_q, any_d;
    logic [IDX_W-1:0]   first_q, first_d;

    // State and datapath registers; handshake/detector outputs are registered
    // from the next-state values so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            bit_q     <= '0;
            cnt_q     <= '0;
            any_q     <= 1'b0;
            first_q   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            det_rst_n <= 1'b0;
            det_xin   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bit_q     <= bit_d;
            cnt_q     <= cnt_d;
            any_q     <= any_d;
            first_q   <= first_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            det_rst_n <= (state_d == SHIFT);
            det_xin   <= (state_d == SHIFT) & sreg_d[0];
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        any_d   = any_q;
        first_d = first_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sreg_d  = in_data;
                    bit_d   = '0;
                    cnt_d   = '0;
                    any_d   = 1'b0;
                    first_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    // det_y is the detector's response to the bit driven this cycle
                    if (det_y) begin
                        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                        if (!any_q) begin
                            any_d   = 1'b1;
                            first_d = bit_q;
                        end
                    end
                    sreg_d = {1'b0, sreg_q[WORD_W-1:1]};
                    bit_d  = bit_q + IDX_W'(1);
                    if (bit_q == LAST_IDX) state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_count = cnt_q;
    assign out_any   = any_q;
    assign out_first = first_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Testbench for seq_scan_ctrl: a "001" Mealy detector model drives det_y for the
// main instance. A second instance with CNT_W=2 and det_y tied high shares the
// same stimulus and must saturate.
module tb_seq_scan_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, abort, out_ready;
    logic [W-1:0] in_data;
    logic         in_ready, det_rst_n, det_xin, det_y, out_valid, out_any;
    logic [3:0]   out_count;
    logic [2:0]   out_first;
    logic         s_in_ready, s_det_rst_n, s_det_xin, s_out_valid, s_out_any;
    logic [1:0]   s_out_count;
    logic [2:0]   s_out_first;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl #(.WORD_W(W), .CNT_W(4), .IDX_W(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .abort(abort), .det_rst_n(det_rst_n), .det_xin(det_xin),
        .det_y(det_y), .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_any(out_any), .out_first(out_first)
    );

    seq_scan_ctrl #(.WORD_W(W), .CNT_W(2), .IDX_W(3)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s_in_ready), .abort(abort), .det_rst_n(s_det_rst_n), .det_xin(s_det_xin),
        .det_y(1'b1), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_count(s_out_count), .out_any(s_out_any), .out_first(s_out_first)
    );

    // "001" detector: remembers the last two bits seen since its reset.
    logic [1:0] hist;
    int         nbits;
    always @(posedge clk) begin
        if (!det_rst_n) begin
            hist  <= 2'b00;
            nbits <= 0;
        end else begin
            hist  <= {hist[0], det_xin};
            nbits <= (nbits < 2) ? nbits + 1 : 2;
        end
    end
    assign det_y = det_rst_n && (nbits >= 2) && (hist == 2'b00) && det_xin;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: scan the word as a bit string and find every "0,0,1" ending at i.
    task automatic model(input logic [W-1:0] w, output int cnt, output int first);
        cnt = 0;
        first = 0;
        for (int i = 2; i < int'(W); i++) begin
            if (w[i] && !w[i-1] && !w[i-2]) begin
                if (cnt == 0) first = i;
                cnt++;
            end
        end
        if (cnt > 15) cnt = 15;
    endtask

    task automatic send_word(input logic [W-1:0] w, input int bp);
        int          lat;
        int          ecnt, efirst;
        logic [W-1:0] seen;
        logic [3:0]  hold_cnt;
        logic        hold_any;
        logic [2:0]  hold_first;
        int          to;
        to = 0;
        while (!in_ready && to < 50) begin step(); to++; end
        check("in_ready before accept", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = w;
        step();
        in_valid = 1'b0;
        in_data  = $urandom;
        check("in_ready in shift", 32'(in_ready), 0);
        check("det_rst_n in shift", 32'(det_rst_n), 1);
        seen = '0;
        lat  = 1;
        while (!out_valid && lat < 50) begin
            if (lat <= int'(W)) seen[lat-1] = det_xin;
            step();
            lat++;
        end
        check("latency", 32'(lat), 32'(W + 1));
        check("det_xin serial order", 32'(seen), 32'(w));
        check("det_rst_n in done", 32'(det_rst_n), 0);
        check("det_xin in done", 32'(det_xin), 0);
        model(w, ecnt, efirst);
        check("out_count", 32'(out_count), 32'(ecnt));
        check("out_any", 32'(out_any), 32'(ecnt != 0));
        check("out_first", 32'(out_first), 32'(efirst));
        check("sat out_count", 32'(s_out_count), 3);
        check("sat out_first", 32'(s_out_first), 0);
        check("sat out_any", 32'(s_out_any), 1);
        hold_cnt = out_count; hold_any = out_any; hold_first = out_first;
        for (int i = 0; i < bp; i++) begin
            in_valid = (i == 0);
            in_data  = $urandom;
            step();
            in_valid = 1'b0;
            check("bp out_valid", 32'(out_valid), 1);
            check("bp in_ready", 32'(in_ready), 0);
            check("bp stable", {hold_cnt, 3'(hold_first), 1'(hold_any)},
                  {out_count, out_first, out_any});
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("out_valid drop", 32'(out_valid), 0);
        check("idle in_ready", 32'(in_ready), 1);
    endtask

    task automatic accept_and_shift(input logic [W-1:0] w, input int extra);
        in_valid = 1'b1;
        in_data  = w;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < extra; i++) step();
    endtask

    initial begin
        int saw;
        reset = 1'b0; in_valid = 1'b0; in_data = '0; abort = 1'b0; out_ready = 1'b0;
        repeat (3) step();
        check("rst in_ready", 32'(in_ready), 1);
        check("rst out_valid", 32'(out_valid), 0);
        check("rst det_rst_n", 32'(det_rst_n), 0);
        check("rst out_count", 32'(out_count), 0);
        check("rst det_xin", 32'(det_xin), 0);
        reset = 1'b1;
        step();

        send_word(8'b0010_0100, 0);
        send_word(8'h00, 2);
        send_word(8'h04, 0);
        send_word(8'h01, 0);
        send_word(8'hFF, 5);

        // abort in the 4th shift cycle
        accept_and_shift(8'h24, 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort in_ready", 32'(in_ready), 1);
        check("abort det_rst_n", 32'(det_rst_n), 0);
        saw = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) saw = 1;
            step();
        end
        check("abort no out_valid", 32'(saw), 0);
        send_word(8'b0010_0100, 1);

        // asynchronous reset mid-shift
        accept_and_shift(8'h24, 3);
        #2 reset = 1'b0;
        #1;
        check("arst in_ready", 32'(in_ready), 1);
        check("arst det_rst_n", 32'(det_rst_n), 0);
        check("arst out_count", 32'(out_count), 0);
        check("arst out_any", 32'(out_any), 0);
        step();
        reset = 1'b1;
        step();
        send_word(8'b1001_0001, 0);

        for (int n = 0; n < 20; n++) send_word(W'($urandom), int'($urandom_range(0, 3)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
